// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM, MMIO window (GPIO, cycle counter, compare timer) and unmapped space.
// Latency: reads are combinational from addr; writes, counters and the timer update at posedge; irq is PEND delayed one cycle.
// Backpressure: none. Every access completes in its own cycle. Optional write-error capture is enabled by macro DMEM_ERR_EN.
module dmem_mmio_responder #(
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [15:0] gpio_out,
    output logic        irq
`ifdef DMEM_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int unsigned IDX_W     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS * 4);

    localparam logic [2:0] OFF_GPIO    = 3'd0;
    localparam logic [2:0] OFF_CYCLE   = 3'd1;
    localparam logic [2:0] OFF_CMP     = 3'd2;
    localparam logic [2:0] OFF_CTRL    = 3'd3;
    localparam logic [2:0] OFF_TCNT    = 3'd4;
    localparam logic [2:0] OFF_ERRADDR = 3'd5;

    // Address decode; addr[1:0] never selects anything
    logic             ram_hit;
    logic             mmio_hit;
    logic [2:0]       mmio_off;
    logic [IDX_W-1:0] ram_idx;
    logic             ram_we;
    logic             mmio_we;

    assign ram_hit  = (addr < RAM_LIMIT);
    assign mmio_hit = (addr[31:5] == MMIO_BASE[31:5]);
    assign mmio_off = addr[4:2];
    assign ram_idx  = addr[IDX_W+1:2];
    assign ram_we   = mem_w && ram_hit;
    assign mmio_we  = mem_w && mmio_hit;

    // Storage and registers
    logic [31:0] mem_q [RAM_WORDS];
    logic [15:0] gpio_q,  gpio_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] cmp_q,   cmp_d;
    logic [31:0] tcnt_q,  tcnt_d;
    logic        en_q,    en_d;
    logic        reload_q, reload_d;
    logic        pend_q,  pend_d;
    logic        irq_q;
    logic        timer_match;

    // Match is judged on pre-edge values only, regardless of any CPU write this cycle
    assign timer_match = en_q && (tcnt_q == cmp_q);

    // RAM array: no reset, so contents survive rst
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= wdata;
        end
    end

    // Next-state for MMIO registers: timer update first, then CPU writes override, then match sets PEND
    always_comb begin
        gpio_d   = gpio_q;
        cycle_d  = cycle_q + 32'd1;
        cmp_d    = cmp_q;
        tcnt_d   = tcnt_q;
        en_d     = en_q;
        reload_d = reload_q;
        pend_d   = pend_q;
        if (en_q) begin
            if (timer_match) begin
                if (reload_q) begin
                    tcnt_d = '0;
                end else begin
                    en_d = 1'b0;
                end
            end else begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end
        if (mmio_we) begin
            case (mmio_off)
                OFF_GPIO: gpio_d = wdata[15:0];
                OFF_CMP:  cmp_d  = wdata;
                OFF_CTRL: begin
                    en_d     = wdata[0];
                    reload_d = wdata[1];
                    if (wdata[2]) begin
                        pend_d = 1'b0;
                    end
                end
                OFF_TCNT: tcnt_d = wdata;
                default:  ;
            endcase
        end
        if (timer_match) begin
            pend_d = 1'b1;
        end
    end

    // MMIO register state with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_q   <= '0;
            cycle_q  <= '0;
            cmp_q    <= '0;
            tcnt_q   <= '0;
            en_q     <= 1'b0;
            reload_q <= 1'b0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            gpio_q   <= gpio_d;
            cycle_q  <= cycle_d;
            cmp_q    <= cmp_d;
            tcnt_q   <= tcnt_d;
            en_q     <= en_d;
            reload_q <= reload_d;
            pend_q   <= pend_d;
            irq_q    <= pend_q;
        end
    end

`ifdef DMEM_ERR_EN
    logic        wr_err;
    logic        err_q,     err_d;
    logic [31:0] erraddr_q, erraddr_d;

    assign wr_err = mem_w && ((addr[1:0] != 2'b00) || !(ram_hit || mmio_hit));

    // Sticky error flag; only the first offending address is kept
    always_comb begin
        err_d     = err_q | wr_err;
        erraddr_d = erraddr_q;
        if (wr_err && !err_q) begin
            erraddr_d = addr;
        end
    end

    // Error capture state with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q     <= 1'b0;
            erraddr_q <= '0;
        end else begin
            err_q     <= err_d;
            erraddr_q <= erraddr_d;
        end
    end

    assign err = err_q;
`endif

    // Combinational read mux; RAM read shows the pre-write word during a write
    always_comb begin
        rdata = '0;
        if (ram_hit) begin
            rdata = mem_q[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_off)
                OFF_GPIO:    rdata = {16'h0000, gpio_q};
                OFF_CYCLE:   rdata = cycle_q;
                OFF_CMP:     rdata = cmp_q;
                OFF_CTRL:    rdata = {29'd0, pend_q, reload_q, en_q};
                OFF_TCNT:    rdata = tcnt_q;
`ifdef DMEM_ERR_EN
                OFF_ERRADDR: rdata = erraddr_q;
`endif
                default:     rdata = '0;
            endcase
        end
    end

    assign gpio_out = gpio_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: vector table for RAM/GPIO/decode, hand sequences for timer and reset.
// Reads are checked at negedge (pre-edge state); flag outputs are checked 1 time unit after posedge.
// Expected read data goes through a scoreboard queue between drive and sample.
module tb_dmem_mmio_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef DMEM_ERR_EN
    localparam logic [31:0] EXP_ERRADDR = 32'h0000_0041;
`else
    localparam logic [31:0] EXP_ERRADDR = 32'h0000_0000;
`endif

    logic        clk;
    logic        rst;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] gpio_out;
    logic        irq;
`ifdef DMEM_ERR_EN
    logic        err;
`endif

    dmem_mmio_responder #(
        .RAM_WORDS(1024),
        .MMIO_BASE(BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_w    (mem_w),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .gpio_out (gpio_out),
        .irq      (irq)
`ifdef DMEM_ERR_EN
        ,
        .err      (err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, optionally compare rdata at negedge, commit at posedge
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic chk, input logic [31:0] exp, input string name);
        logic [31:0] e;
        mem_w = we;
        addr  = a;
        wdata = d;
        if (chk) sb_q.push_back(exp);
        @(negedge clk);
        if (chk) begin
            e = sb_q.pop_front();
            check32(name, rdata, e);
        end
        @(posedge clk);
        #1;
        mem_w = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector table: {we, addr, wdata, chk, exp_rdata}
        vq.push_back('{1'b1, 32'h0000_0041, 32'h0BAD_F00D, 1'b0, 32'h0});
        vq.push_back('{1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'h0BAD_F00D});
        vq.push_back('{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0});
        vq.push_back('{1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'hDEAD_BEEF});
        vq.push_back('{1'b1, 32'h0000_0040, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF});
        vq.push_back('{1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'h1234_5678});
        vq.push_back('{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 32'h0});
        vq.push_back('{1'b1, 32'h0000_1000, 32'hAAAA_5555, 1'b0, 32'h0});
        vq.push_back('{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0});
        vq.push_back('{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'hCAFE_F00D});
        vq.push_back('{1'b1, BASE,          32'hFFFF_FFFF, 1'b0, 32'h0});
        vq.push_back('{1'b0, BASE,          32'h0,         1'b1, 32'h0000_FFFF});
        vq.push_back('{1'b1, BASE + 32'h20, 32'h0000_1234, 1'b0, 32'h0});
        vq.push_back('{1'b0, BASE + 32'h20, 32'h0,         1'b1, 32'h0});
        vq.push_back('{1'b0, BASE,          32'h0,         1'b1, 32'h0000_FFFF});
        vq.push_back('{1'b0, BASE + 32'h14, 32'h0,         1'b1, EXP_ERRADDR});
        vq.push_back('{1'b1, BASE + 32'h1C, 32'h0000_0055, 1'b0, 32'h0});
        vq.push_back('{1'b0, BASE + 32'h1C, 32'h0,         1'b1, 32'h0});
        vq.push_back('{1'b0, BASE + 32'h14, 32'h0,         1'b1, EXP_ERRADDR});
        vq.push_back('{1'b0, BASE + 32'h0C, 32'h0,         1'b1, 32'h0});

        // Reset
        rst   = 1'b0;
        mem_w = 1'b0;
        addr  = BASE;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_gpio_out", {16'h0, gpio_out}, 32'h0);
        check32("rst_irq", {31'h0, irq}, 32'h0);
        check32("rst_gpio_rd", rdata, 32'h0);
`ifdef DMEM_ERR_EN
        check32("rst_err", {31'h0, err}, 32'h0);
`endif
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, BASE + 32'h04, 32'h0, 1'b1, 32'(i), $sformatf("cycle%0d", i));
        end

        // Table-driven RAM / GPIO / decode checks
        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].we, vq[i].addr, vq[i].wdata, vq[i].chk, vq[i].exp, $sformatf("vec%0d", i));
        end
        check32("gpio_out_ffff", {16'h0, gpio_out}, 32'h0000_FFFF);
`ifdef DMEM_ERR_EN
        check32("err_sticky", {31'h0, err}, 32'h1);
`endif

        // One-shot timer: irq rises 5 cycles after the CTRL write edge
        step(1'b1, BASE + 32'h08, 32'd3, 1'b0, 32'h0, "");
        step(1'b1, BASE + 32'h10, 32'd0, 1'b0, 32'h0, "");
        step(1'b1, BASE + 32'h0C, 32'h1, 1'b0, 32'h0, "");
        check32("os_irq0", {31'h0, irq}, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, BASE + 32'h0C, 32'h0, 1'b1, (k >= 5) ? 32'h4 : 32'h1, $sformatf("os_ctrl%0d", k));
            check32($sformatf("os_irq%0d", k), {31'h0, irq}, (k >= 5) ? 32'h1 : 32'h0);
        end
        step(1'b0, BASE + 32'h10, 32'h0, 1'b1, 32'd3, "os_tcnt_hold_a");
        step(1'b0, BASE + 32'h10, 32'h0, 1'b1, 32'd3, "os_tcnt_hold_b");
        step(1'b1, BASE + 32'h0C, 32'h4, 1'b0, 32'h0, "");
        step(1'b0, BASE + 32'h0C, 32'h0, 1'b1, 32'h0, "os_pend_clr");
        check32("os_irq_clr", {31'h0, irq}, 32'h0);

        // Reload timer: match every 3 cycles
        step(1'b1, BASE + 32'h08, 32'd2, 1'b0, 32'h0, "");
        step(1'b1, BASE + 32'h10, 32'd0, 1'b0, 32'h0, "");
        step(1'b1, BASE + 32'h0C, 32'h3, 1'b0, 32'h0, "");
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, BASE + 32'h10, 32'h0, 1'b1, 32'((k - 1) % 3), $sformatf("rl_tcnt%0d", k));
            if (k == 3) check32("rl_irq_pre", {31'h0, irq}, 32'h0);
            if (k == 4) check32("rl_irq_set", {31'h0, irq}, 32'h1);
        end
        step(1'b1, BASE + 32'h0C, 32'h7, 1'b0, 32'h0, "");
        step(1'b0, BASE + 32'h0C, 32'h0, 1'b1, 32'h3, "rl_pend_clr");
        step(1'b1, BASE + 32'h0C, 32'h4, 1'b1, 32'h3, "rl_pre_match");
        step(1'b0, BASE + 32'h0C, 32'h0, 1'b1, 32'h4, "rl_set_wins");
        step(1'b0, BASE + 32'h10, 32'h0, 1'b1, 32'h0, "rl_tcnt_stop_a");
        step(1'b0, BASE + 32'h10, 32'h0, 1'b1, 32'h0, "rl_tcnt_stop_b");
        check32("rl_irq_hold", {31'h0, irq}, 32'h1);
        check32("pre_rst_gpio", {16'h0, gpio_out}, 32'h0000_FFFF);

        // Asynchronous reset mid-operation; RAM must survive
        #2;
        rst = 1'b0;
        #1;
        check32("arst_irq", {31'h0, irq}, 32'h0);
        check32("arst_gpio", {16'h0, gpio_out}, 32'h0);
        addr = BASE + 32'h0C;
        #1;
        check32("arst_ctrl", rdata, 32'h0);
`ifdef DMEM_ERR_EN
        check32("arst_err", {31'h0, err}, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, BASE + 32'h04, 32'h0, 1'b1, 32'd0, "arst_cycle0");
        step(1'b0, BASE + 32'h04, 32'h0, 1'b1, 32'd1, "arst_cycle1");
        step(1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'h1234_5678, "ram_retained");
        step(1'b0, BASE + 32'h14, 32'h0, 1'b1, 32'h0, "arst_erraddr");
        step(1'b0, BASE, 32'h0, 1'b1, 32'h0, "arst_gpio_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
